// File: rtl/icache_pkg.sv
// Instruction-cache geometry shared by the refill path, plus the line-fill state encoding.
package icache_pkg;

   localparam int LINE_OFST_LSB  = 2;
   localparam int LINE_IDX_LSB   = 5;
   localparam int WORDS_PER_LINE = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fill_state_e;

endpackage

// File: rtl/ic_fill_engine_if.sv
// IC refill port and main-memory read port of the line-fill engine.
// The master modport is the engine side; slave is the IC/memory side.
interface ic_fill_engine_if #(
   parameter int OFST_W = 3
);

   logic              fill_req_valid;
   logic              fill_req_ready;
   logic [31:0]       fill_req_addr;
   logic              abort;
   logic              fill_word_valid;
   logic [31:0]       fill_word_data;
   logic [OFST_W-1:0] fill_word_ofst;
   logic              fill_done;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [31:0]       mem_req_addr;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_data;

   modport master (
      input  fill_req_valid, fill_req_addr, abort,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output fill_req_ready, fill_word_valid, fill_word_data, fill_word_ofst, fill_done,
      output mem_req_valid, mem_req_addr
   );

   modport slave (
      output fill_req_valid, fill_req_addr, abort,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  fill_req_ready, fill_word_valid, fill_word_data, fill_word_ofst, fill_done,
      input  mem_req_valid, mem_req_addr
   );

endinterface

// File: rtl/ic_fill_engine.sv
// I-cache line-fill engine: critical-word-first wrapping reads to memory with a bounded
// number of reads in flight; returned words are forwarded to the IC with their line offset.
module ic_fill_engine
   import icache_pkg::*;
#(
   parameter int WORDS_PER_LINE  = icache_pkg::WORDS_PER_LINE,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             clk,
   input  logic             reset,
   ic_fill_engine_if.master bus
);

   localparam int OFST_W  = $clog2(WORDS_PER_LINE);
   localparam int CNT_W   = OFST_W + 1;
   localparam int OUTST_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int LINE_W  = 32 - LINE_IDX_LSB;

   localparam logic [CNT_W-1:0]   WORDS_C   = CNT_W'(WORDS_PER_LINE);
   localparam logic [OUTST_W-1:0] MAX_OUT_C = OUTST_W'(MAX_OUTSTANDING);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_FILL  = FILL;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]         state_q,      state_d;
   logic [LINE_W-1:0]  line_q,       line_d;
   logic [OFST_W-1:0]  start_q,      start_d;
   logic [CNT_W-1:0]   issue_cnt_q,  issue_cnt_d;
   logic [CNT_W-1:0]   recv_cnt_q,   recv_cnt_d;
   logic [OUTST_W-1:0] outst_q,      outst_d;
   logic               word_valid_q, word_valid_d;
   logic [31:0]        word_data_q,  word_data_d;
   logic [OFST_W-1:0]  word_ofst_q,  word_ofst_d;

   logic               mem_req_valid_s;
   logic               issue_s;
   logic               resp_s;
   logic [OFST_W-1:0]  req_ofst_s;
   logic               unused_addr_s;

   assign unused_addr_s = ^bus.fill_req_addr[LINE_OFST_LSB-1:0];

   // Request handshake; abort suppresses the request in the very cycle it is raised.
   always_comb begin
      req_ofst_s      = start_q + issue_cnt_q[OFST_W-1:0];
      mem_req_valid_s = (state_q == ST_FILL) && !bus.abort &&
                        (issue_cnt_q < WORDS_C) && (outst_q < MAX_OUT_C);
      issue_s         = mem_req_valid_s && bus.mem_req_ready;
      resp_s          = bus.mem_resp_valid && ((state_q == ST_FILL) || (state_q == ST_DRAIN));
   end

   // Fill sequencing, in-flight accounting and the registered word return.
   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      start_d      = start_q;
      issue_cnt_d  = issue_s ? (issue_cnt_q + CNT_W'(1'b1)) : issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      word_valid_d = 1'b0;
      word_data_d  = word_data_q;
      word_ofst_d  = word_ofst_q;
      case ({issue_s, resp_s})
         2'b10:   outst_d = outst_q + OUTST_W'(1'b1);
         2'b01:   outst_d = outst_q - OUTST_W'(1'b1);
         default: outst_d = outst_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (bus.fill_req_valid) begin
               line_d      = bus.fill_req_addr[31:LINE_IDX_LSB];
               start_d     = bus.fill_req_addr[LINE_OFST_LSB +: OFST_W];
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               outst_d     = '0;
               state_d     = ST_FILL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (resp_s) begin
               word_valid_d = 1'b1;
               word_data_d  = bus.mem_resp_data;
               word_ofst_d  = start_q + recv_cnt_q[OFST_W-1:0];
               recv_cnt_d   = recv_cnt_q + CNT_W'(1'b1);
            end else begin
               recv_cnt_d = recv_cnt_q;
            end
            if (bus.abort) begin
               state_d = (outst_d == '0) ? ST_IDLE : ST_DRAIN;
            end else if (recv_cnt_d == WORDS_C) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_DRAIN: begin
            if (outst_d == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         line_q       <= '0;
         start_q      <= '0;
         issue_cnt_q  <= '0;
         recv_cnt_q   <= '0;
         outst_q      <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= 32'h0000_0000;
         word_ofst_q  <= '0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         start_q      <= start_d;
         issue_cnt_q  <= issue_cnt_d;
         recv_cnt_q   <= recv_cnt_d;
         outst_q      <= outst_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
         word_ofst_q  <= word_ofst_d;
      end
   end

   assign bus.fill_req_ready  = (state_q == ST_IDLE);
   assign bus.fill_word_valid = word_valid_q;
   assign bus.fill_word_data  = word_data_q;
   assign bus.fill_word_ofst  = word_ofst_q;
   assign bus.fill_done       = (state_q == ST_DONE);
   assign bus.mem_req_valid   = mem_req_valid_s;
   assign bus.mem_req_addr    = {line_q, req_ofst_s, {LINE_OFST_LSB{1'b0}}};

`ifndef SYNTHESIS
   // Memory answered a read nobody issued.
   always_ff @(posedge clk) begin
      if (reset && (state_q == ST_IDLE) && bus.mem_resp_valid) begin
         $error("ic_fill_engine: memory response while idle");
      end
   end
`endif

endmodule

// File: tb/tb_ic_fill_engine.sv
// Directed bench for ic_fill_engine: a table of whole-line fills against an in-order
// fixed-latency memory model, plus reset/abort sequences.
module tb_ic_fill_engine;

   localparam logic [31:0] DATA_KEY = 32'hC3A5_0F00;

   typedef struct {
      logic [31:0]      addr;
      int               lat;
      int               stall_from;
      int               stall_len;
      int               exp_peak;
      logic [0:7][31:0] exp_req;
      logic [0:7][2:0]  exp_ofst;
   } fill_vec_t;

   logic clk;
   logic reset;

   ic_fill_engine_if #(.OFST_W(3)) bus ();

   ic_fill_engine #(.WORDS_PER_LINE(8), .MAX_OUTSTANDING(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   fill_vec_t   vecs [5];
   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          rl_from = -1;
   int          rl_to = -2;
   int          n_iss = 0;
   int          n_rsp = 0;
   int          peak_out = 0;
   int          q_due [$];
   logic [31:0] q_dat [$];

   logic        smp_ready, smp_req_valid, smp_req_rdy_in, smp_resp_in, smp_word_valid, smp_done;
   logic [31:0] smp_req_addr, smp_word_data;
   logic [2:0]  smp_word_ofst;
   int          smp_cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample at negedge, run the memory model, then drive the next cycle's inputs.
   task automatic tick();
      int cur_out;
      @(negedge clk);
      smp_ready      = bus.fill_req_ready;
      smp_req_valid  = bus.mem_req_valid;
      smp_req_rdy_in = bus.mem_req_ready;
      smp_resp_in    = bus.mem_resp_valid;
      smp_req_addr   = bus.mem_req_addr;
      smp_word_valid = bus.fill_word_valid;
      smp_word_data  = bus.fill_word_data;
      smp_word_ofst  = bus.fill_word_ofst;
      smp_done       = bus.fill_done;
      smp_cyc        = cyc;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         cur_out = n_iss - n_rsp + (bus.mem_resp_valid ? 1 : 0) + 1;
         if (cur_out > peak_out) peak_out = cur_out;
         q_due.push_back(cyc + mem_lat);
         q_dat.push_back(bus.mem_req_addr ^ DATA_KEY);
         n_iss++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = q_dat.pop_front();
         void'(q_due.pop_front());
         n_rsp++;
      end else begin
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_data  = 32'h0000_0000;
      end
      bus.mem_req_ready = !(cyc >= rl_from && cyc <= rl_to);
   endtask

   task automatic set_vec(input int i, input logic [31:0] a, input int lat, input int sf,
                          input int sl, input int pk, input logic [255:0] req, input logic [23:0] of);
      vecs[i].addr       = a;
      vecs[i].lat        = lat;
      vecs[i].stall_from = sf;
      vecs[i].stall_len  = sl;
      vecs[i].exp_peak   = pk;
      vecs[i].exp_req    = req;
      vecs[i].exp_ofst   = of;
   endtask

   task automatic run_fill(input int vi);
      int cap, got_req, got_word, done_cnt, last_word_cyc, done_cyc, first_req_cyc;
      logic        prev_stall;
      logic [31:0] prev_addr;
      got_req = 0; got_word = 0; done_cnt = 0;
      last_word_cyc = -1; done_cyc = -1; first_req_cyc = -1;
      prev_stall = 1'b0; prev_addr = 32'h0000_0000;
      n_iss = 0; n_rsp = 0; peak_out = 0;
      mem_lat = vecs[vi].lat;
      cap = cyc;
      if (vecs[vi].stall_len > 0) begin
         rl_from = cap + vecs[vi].stall_from;
         rl_to   = rl_from + vecs[vi].stall_len - 1;
      end else begin
         rl_from = -1;
         rl_to   = -2;
      end
      bus.fill_req_valid = 1'b1;
      bus.fill_req_addr  = vecs[vi].addr;
      tick();
      chk("capture_ready", smp_ready, 1'b1);
      chk("capture_no_req", smp_req_valid, 1'b0);
      bus.fill_req_valid = 1'b0;
      for (int k = 0; k < 200 && done_cnt == 0; k++) begin
         tick();
         if (smp_req_valid && first_req_cyc < 0) first_req_cyc = smp_cyc;
         if (prev_stall) begin
            chk("stall_hold_valid", smp_req_valid, 1'b1);
            chk("stall_hold_addr", smp_req_addr, prev_addr);
         end
         if (smp_req_valid && smp_req_rdy_in) begin
            if (got_req < 8) chk("req_addr", smp_req_addr, vecs[vi].exp_req[got_req]);
            else chk("req_overrun", got_req, 7);
            got_req++;
         end
         prev_stall = smp_req_valid && !smp_req_rdy_in;
         prev_addr  = smp_req_addr;
         if (smp_word_valid) begin
            if (got_word < 8) begin
               chk("word_ofst", smp_word_ofst, vecs[vi].exp_ofst[got_word]);
               chk("word_data", smp_word_data, vecs[vi].exp_req[got_word] ^ DATA_KEY);
            end else begin
               chk("word_overrun", got_word, 7);
            end
            got_word++;
            last_word_cyc = smp_cyc;
         end
         if (smp_done) begin
            done_cnt++;
            done_cyc = smp_cyc;
         end
      end
      if (done_cnt == 0) chk("fill_timeout", done_cnt, 1);
      chk("req_count", got_req, 8);
      chk("word_count", got_word, 8);
      chk("peak_outstanding", peak_out, vecs[vi].exp_peak);
      chk("first_req_latency", first_req_cyc, cap + 1);
      chk("done_after_last_word", done_cyc >= last_word_cyc, 1'b1);
      tick();
      chk("done_single_pulse", smp_done, 1'b0);
      chk("idle_after_done", smp_ready, 1'b1);
      chk("no_word_after_done", smp_word_valid, 1'b0);
      rl_from = -1;
      rl_to   = -2;
      tick();
   endtask

   initial begin
      int ready_cyc, last_rsp_cyc, drained;
      logic any_req, any_word, any_done;

      reset              = 1'b0;
      bus.fill_req_valid = 1'b0;
      bus.fill_req_addr  = 32'h0000_0000;
      bus.abort          = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'h0000_0000;

      set_vec(0, 32'h0000_1000, 1, 0, 0, 2,
              {32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h101C},
              {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
      set_vec(1, 32'h0000_1014, 1, 0, 0, 2,
              {32'h1014, 32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010},
              {3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
      set_vec(2, 32'h0000_2008, 10, 0, 0, 4,
              {32'h2008, 32'h200C, 32'h2010, 32'h2014, 32'h2018, 32'h201C, 32'h2000, 32'h2004},
              {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1});
      set_vec(3, 32'h0000_301C, 3, 2, 5, 4,
              {32'h301C, 32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014, 32'h3018},
              {3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
      set_vec(4, 32'hFFFF_FFE7, 2, 0, 0, 3,
              {32'hFFFF_FFE4, 32'hFFFF_FFE8, 32'hFFFF_FFEC, 32'hFFFF_FFF0,
               32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFE0},
              {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0});

      #12;
      chk("rst_fill_req_ready", bus.fill_req_ready, 1'b1);
      chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0000_0000);
      chk("rst_fill_word_valid", bus.fill_word_valid, 1'b0);
      chk("rst_fill_word_data", bus.fill_word_data, 32'h0000_0000);
      chk("rst_fill_word_ofst", bus.fill_word_ofst, 3'd0);
      chk("rst_fill_done", bus.fill_done, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      tick();

      for (int v = 0; v < 5; v++) run_fill(v);

      // Reset asserted mid-fill after three requests have gone out.
      n_iss = 0; n_rsp = 0; mem_lat = 10;
      bus.fill_req_valid = 1'b1;
      bus.fill_req_addr  = 32'h0000_4000;
      tick();
      bus.fill_req_valid = 1'b0;
      for (int k = 0; k < 20 && n_iss < 3; k++) tick();
      chk("midreset_issued", n_iss, 3);
      #2;
      reset = 1'b0;
      #1;
      q_due.delete();
      q_dat.delete();
      bus.mem_resp_valid = 1'b0;
      chk("midreset_ready_async", bus.fill_req_ready, 1'b1);
      chk("midreset_req_async", bus.mem_req_valid, 1'b0);
      chk("midreset_word_async", bus.fill_word_valid, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("midreset_ready_next", smp_ready, 1'b1);
      chk("midreset_req_next", smp_req_valid, 1'b0);
      chk("midreset_word_next", smp_word_valid, 1'b0);
      tick();

      // Abort with three reads outstanding: drain and discard them.
      n_iss = 0; n_rsp = 0; mem_lat = 10;
      bus.fill_req_valid = 1'b1;
      bus.fill_req_addr  = 32'h0000_5000;
      tick();
      bus.fill_req_valid = 1'b0;
      for (int k = 0; k < 20 && n_iss < 3; k++) tick();
      chk("abort_issued_before", n_iss, 3);
      bus.abort = 1'b1;
      tick();
      chk("abort_blocks_req", smp_req_valid, 1'b0);
      bus.abort = 1'b0;
      any_req = 1'b0; any_word = 1'b0; any_done = 1'b0;
      ready_cyc = -1; last_rsp_cyc = -1; drained = 0;
      for (int k = 0; k < 40 && ready_cyc < 0; k++) begin
         tick();
         any_req  = any_req | smp_req_valid;
         any_word = any_word | smp_word_valid;
         any_done = any_done | smp_done;
         if (smp_resp_in) begin
            drained++;
            last_rsp_cyc = smp_cyc;
         end
         if (smp_ready) ready_cyc = smp_cyc;
      end
      chk("drain_no_req", any_req, 1'b0);
      chk("drain_no_word", any_word, 1'b0);
      chk("drain_no_done", any_done, 1'b0);
      chk("drain_resp_count", drained, 3);
      chk("drain_idle_after_last", ready_cyc, last_rsp_cyc + 1);
      chk("drain_queue_empty", q_due.size(), 0);
      tick();

      // Abort in the first fill cycle with nothing outstanding: straight back to idle.
      n_iss = 0; n_rsp = 0; mem_lat = 1;
      bus.fill_req_valid = 1'b1;
      bus.fill_req_addr  = 32'h0000_6000;
      tick();
      bus.fill_req_valid = 1'b0;
      bus.abort = 1'b1;
      tick();
      chk("abort0_no_req", smp_req_valid, 1'b0);
      chk("abort0_busy", smp_ready, 1'b0);
      bus.abort = 1'b0;
      tick();
      chk("abort0_idle", smp_ready, 1'b1);
      chk("abort0_issued", n_iss, 0);

      // Abort while idle has no effect.
      bus.abort = 1'b1;
      tick();
      chk("idle_abort_ready", smp_ready, 1'b1);
      chk("idle_abort_req", smp_req_valid, 1'b0);
      bus.abort = 1'b0;
      tick();
      chk("idle_abort_done", smp_done, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
